// File: rtl/xpb_pkg.sv
// ---------------------------------------------------------------------------
// xpb_pkg
// Shared constants and the controller state type for the XPB table
// generator (xpb_table_gen) and its modular-add datapath (xpb_modadd).
//   XPB_WIDTH  : default width of modulus, base and table entries
//   XPB_ADDR_W : default table address width
//   XPB_DEPTH  : default table depth (2**XPB_ADDR_W)
// ---------------------------------------------------------------------------
package xpb_pkg;

    localparam int XPB_WIDTH  = 1024;
    localparam int XPB_ADDR_W = 5;
    localparam int XPB_DEPTH  = 2 ** XPB_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        ZERO,
        ADD,
        REDUCE,
        FIN
    } xpb_state_e;

endpackage : xpb_pkg

// File: rtl/xpb_modadd.sv
// ---------------------------------------------------------------------------
// xpb_modadd
// Conditional-subtract reduction: result = sum mod m, valid for sum < 2*m.
// Ports:
//   sum    [XPB_WIDTH:0]   in  : unreduced sum including carry-out bit
//   m      [XPB_WIDTH-1:0] in  : modulus
//   result [XPB_WIDTH-1:0] out : reduced value
// ---------------------------------------------------------------------------
module xpb_modadd
    import xpb_pkg::*;
#(
    parameter int XPB_WIDTH = xpb_pkg::XPB_WIDTH
) (
    input  logic [XPB_WIDTH:0]   sum,
    input  logic [XPB_WIDTH-1:0] m,
    output logic [XPB_WIDTH-1:0] result
);

    logic                 ge_m;
    logic [XPB_WIDTH-1:0] diff;

    // A carry-out means sum >= 2**XPB_WIDTH > m, so the subtraction is forced.
    assign ge_m = sum[XPB_WIDTH] | (sum[XPB_WIDTH-1:0] >= m);

    // The true difference is below 2**XPB_WIDTH, so modular wrap of the low
    // bits yields it exactly even when the carry bit is set.
    assign diff   = sum[XPB_WIDTH-1:0] - m;
    assign result = ge_m ? diff : sum[XPB_WIDTH-1:0];

endmodule : xpb_modadd

// File: rtl/xpb_table_gen.sv
// ---------------------------------------------------------------------------
// xpb_table_gen
// Generates the table T[i] = (i*B) mod M for i = 0 .. 2**XPB_ADDR_W-1 by
// repeated modular addition, streaming each entry out as a RAM write.
// Optional build macro: XPB_GEN_RANGE_CHECK_EN -- rejects a start with B >= M
// by pulsing err instead of running; without it err is tied low.
// Ports:
//   clk      in  : clock, rising edge
//   rst_n    in  : synchronous active-low reset
//   start    in  : one-cycle generate request, honoured only when idle
//   modulus  in  : M, captured on an accepted start
//   base     in  : B, captured on an accepted start
//   busy     out : generation in progress
//   wr_en    out : table write strobe
//   wr_addr  out : table index i
//   wr_data  out : (i*B) mod M, zero when wr_en is low
//   done     out : one-cycle pulse after the last write
//   err      out : one-cycle range-error pulse
// All outputs are registered.
// ---------------------------------------------------------------------------
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int XPB_WIDTH  = xpb_pkg::XPB_WIDTH,
    parameter int XPB_ADDR_W = xpb_pkg::XPB_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [XPB_WIDTH-1:0]  modulus,
    input  logic [XPB_WIDTH-1:0]  base,
    output logic                  busy,
    output logic                  wr_en,
    output logic [XPB_ADDR_W-1:0] wr_addr,
    output logic [XPB_WIDTH-1:0]  wr_data,
    output logic                  done,
    output logic                  err
);

    xpb_state_e            state_q, state_d;
    logic [XPB_WIDTH-1:0]  m_q, b_q;
    logic [XPB_WIDTH:0]    sum_p0;
    logic [XPB_WIDTH-1:0]  acc_p1;
    logic [XPB_ADDR_W-1:0] idx_q;
    logic [XPB_WIDTH-1:0]  red;
    logic                  last_idx;

    logic                  busy_d, wr_en_d, done_d;
    logic [XPB_ADDR_W-1:0] wr_addr_d;
    logic [XPB_WIDTH-1:0]  wr_data_d;
`ifdef XPB_GEN_RANGE_CHECK_EN
    logic                  err_d;
`endif

    assign last_idx = &idx_q;

    xpb_modadd #(
        .XPB_WIDTH (XPB_WIDTH)
    ) u_modadd (
        .sum    (sum_p0),
        .m      (m_q),
        .result (red)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output values are computed for the state being entered, so that the
    // registered outputs line up with that state's cycle.
    always_comb begin
        state_d   = state_q;
        busy_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        done_d    = 1'b0;
`ifdef XPB_GEN_RANGE_CHECK_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef XPB_GEN_RANGE_CHECK_EN
                    if (base >= modulus) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ZERO;
                        busy_d  = 1'b1;
                        wr_en_d = 1'b1;
                    end
`else
                    state_d = ZERO;
                    busy_d  = 1'b1;
                    wr_en_d = 1'b1;
`endif
                end
            end
            ZERO: begin
                state_d = ADD;
                busy_d  = 1'b1;
            end
            ADD: begin
                state_d   = REDUCE;
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_data_d = red;
            end
            REDUCE: begin
                if (last_idx) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = ADD;
                    busy_d  = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage p0: operands and the carry-preserving sum acc + B, registered on
    // entry to ADD (acc already holds the previous entry at that point).
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            m_q <= modulus;
            b_q <= base;
        end
        if (state_q == ZERO || state_q == REDUCE) begin
            sum_p0 <= {1'b0, acc_p1} + {1'b0, b_q};
        end
    end

    // Stage p1: reduced accumulator and entry index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_p1 <= '0;
            idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_p1 <= '0;
                        idx_q  <= '0;
                    end
                end
                ZERO: begin
                    idx_q <= idx_q + XPB_ADDR_W'(1);
                end
                ADD: begin
                    acc_p1 <= red;
                end
                REDUCE: begin
                    if (!last_idx) begin
                        idx_q <= idx_q + XPB_ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            busy    <= busy_d;
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
            done    <= done_d;
        end
    end

`ifdef XPB_GEN_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule : xpb_table_gen

// File: tb/tb_xpb_table_gen.sv
module tb_xpb_table_gen;

    localparam int W  = 1024;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  modulus;
    logic [W-1:0]  base;
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] got [32];

    xpb_table_gen #(
        .XPB_WIDTH  (W),
        .XPB_ADDR_W (AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .modulus (modulus),
        .base    (base),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
                     tag, obs[W-1 -: 64], obs[63:0], exp[W-1 -: 64], exp[63:0]);
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: entry i of the table is (i*B) mod M, by plain arithmetic.
    function automatic logic [W-1:0] ref_entry(input logic [W-1:0] m, input logic [W-1:0] b,
                                               input int i);
        logic [W+7:0] prod;
        logic [W+7:0] r;
        prod = {8'd0, b} * (W+8)'(i);
        r    = prod % {8'd0, m};
        return r[W-1:0];
    endfunction

    // One generation run. restart_cyc > 0: extra start pulse in that cycle.
    // rst_cyc > 0: reset asserted in that cycle. bad: range error expected.
    task automatic run(input logic [W-1:0] m, input logic [W-1:0] b,
                       input int restart_cyc, input int rst_cyc, input bit bad);
        int  nwr;
        int  ndone;
        int  exp_nwr;
        bit  aborted;
        bit  e_wr, e_busy, e_done, e_err;
        int  ent;
        nwr   = 0;
        ndone = 0;
        @(negedge clk);
        modulus = m;
        base    = b;
        start   = 1'b1;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge clk);
            aborted = (rst_cyc > 0) && (cyc > rst_cyc);
            e_wr    = !aborted && !bad && (cyc == 1 || (cyc % 2 == 1 && cyc <= 63));
            e_busy  = !aborted && !bad && (cyc <= 63);
            e_done  = !aborted && !bad && (cyc == 64);
            e_err   = bad && (cyc == 1);
            ent     = (cyc - 1) / 2;
            chk($sformatf("wr_en@%0d", cyc), W'(wr_en), W'(e_wr));
            chk($sformatf("busy@%0d", cyc), W'(busy), W'(e_busy));
            chk($sformatf("done@%0d", cyc), W'(done), W'(e_done));
            chk($sformatf("err@%0d", cyc), W'(err), W'(e_err));
            if (e_wr) begin
                chk($sformatf("wr_addr@%0d", cyc), W'(wr_addr), W'(ent));
                chk($sformatf("wr_data[%0d]", ent), wr_data, ref_entry(m, b, ent));
            end else begin
                chk($sformatf("wd_idle@%0d", cyc), wr_data, '0);
            end
            if (wr_en) begin
                nwr++;
                got[wr_addr] = wr_data;
            end
            if (done) ndone++;
            // Scramble the live inputs; a run must only use captured values.
            start   = (cyc == restart_cyc);
            modulus = rand_wide();
            base    = rand_wide();
            rst_n   = !(rst_cyc > 0 && cyc == rst_cyc);
        end
        start = 1'b0;
        rst_n = 1'b1;
        if (bad) exp_nwr = 0;
        else if (rst_cyc > 0) exp_nwr = (rst_cyc + 1) / 2;
        else exp_nwr = 32;
        chk("n_writes", W'(nwr), W'(exp_nwr));
        chk("n_done", W'(ndone), W'((bad || rst_cyc > 0) ? 0 : 1));
    endtask

    initial begin
        logic [W-1:0] m;
        logic [W-1:0] b;
        logic [W-1:0] h;

        rst_n   = 1'b0;
        start   = 1'b0;
        modulus = '0;
        base    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_wr_en", W'(wr_en), '0);
        chk("rst_wr_addr", W'(wr_addr), '0);
        chk("rst_wr_data", wr_data, '0);
        chk("rst_done", W'(done), '0);
        chk("rst_err", W'(err), '0);
        rst_n = 1'b1;

        run(W'(13), W'(5), 0, 0, 1'b0);
        chk("m13_e3", got[3], W'(2));
        chk("m13_e13", got[13], W'(0));
        chk("m13_e31", got[31], W'(12));

        run(W'(10), W'(5), 0, 0, 1'b0);
        chk("m10_e2", got[2], W'(0));
        chk("m10_e3", got[3], W'(5));

        h = '0;
        h[W-1] = 1'b1;
        run('1, h, 0, 0, 1'b0);
        chk("carry_e1", got[1], h);
        chk("carry_e2", got[2], W'(1));
        chk("carry_e3", got[3], h | W'(1));

        m = rand_wide() | W'(1);
        b = rand_wide() % m;
        run(m, b, 10, 0, 1'b0);

        m = rand_wide() | W'(1);
        b = rand_wide() % m;
        run(m, b, 0, 20, 1'b0);

        for (int r = 0; r < 3; r++) begin
            if (r == 1) begin
                m = W'($urandom_range(2, 1000));
                b = W'($urandom_range(0, 1999)) % m;
            end else begin
                m = rand_wide();
                if (m == '0) m = W'(7);
                b = rand_wide() % m;
            end
            run(m, b, 0, 0, 1'b0);
        end

`ifdef XPB_GEN_RANGE_CHECK_EN
        run(W'(13), W'(13), 0, 0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_xpb_table_gen
